// File: rtl/pc_gen.sv
// Fetch-address generator: registered PC with flush/stall/branch priority and a
// one-entry pending-redirect buffer. Optional alignment check via PCGEN_MISALIGN_CHK_EN.
module pc_gen #(
    parameter int unsigned              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]        RESET_VEC  = {ADDR_W{1'b0}},
    parameter int unsigned              INST_BYTES = 4,
    parameter int unsigned              STALL_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                branch,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   flush_addr,
    output logic [ADDR_W-1:0]   pc,
    output logic                ce,
    output logic                redirect_pending
`ifdef PCGEN_MISALIGN_CHK_EN
    ,
    output logic                addr_misalign
`endif
);

    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 32'd1);

    typedef enum logic [0:0] {
        ST_RAMP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

`ifdef PCGEN_MISALIGN_CHK_EN
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
        return a & ~LOW_MASK;
    endfunction

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
        return (a & LOW_MASK) != {ADDR_W{1'b0}};
    endfunction
`endif

    state_t             state_r;
    state_t             state_nxt_s;
    logic               ce_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  pc_seq_s;
    logic [ADDR_W-1:0]  pc_nxt_s;
    logic               pend_v_r;
    logic               pend_v_nxt_s;
    logic [ADDR_W-1:0]  pend_a_r;
    logic [ADDR_W-1:0]  pend_a_nxt_s;
    logic               redir_s;
    logic [ADDR_W-1:0]  redir_tgt_s;
    logic               unused_stall_s;

    // Upper stall bits belong to later pipeline stages.
    assign unused_stall_s = ^stall;

    // Ramp state register: one cycle of RESET_VEC loading before fetch starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RAMP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and redirect selection, highest priority first.
    always_comb begin
        state_nxt_s  = state_r;
        pc_seq_s     = pc_r;
        pend_v_nxt_s = pend_v_r;
        pend_a_nxt_s = pend_a_r;
        redir_s      = 1'b0;
        redir_tgt_s  = pc_r;
        case (state_r)
            ST_RAMP: begin
                state_nxt_s  = ST_RUN;
                pc_seq_s     = RESET_VEC;
                pend_v_nxt_s = 1'b0;
                pend_a_nxt_s = {ADDR_W{1'b0}};
            end
            ST_RUN: begin
                if (flush) begin
                    redir_s      = 1'b1;
                    redir_tgt_s  = flush_addr;
                    pend_v_nxt_s = 1'b0;
                end else if (stall[0]) begin
                    if (branch) begin
                        pend_v_nxt_s = 1'b1;
                        pend_a_nxt_s = b_addr;
                    end else begin
                        pend_v_nxt_s = pend_v_r;
                    end
                end else if (branch) begin
                    redir_s      = 1'b1;
                    redir_tgt_s  = b_addr;
                    pend_v_nxt_s = 1'b0;
                end else if (pend_v_r) begin
                    redir_s      = 1'b1;
                    redir_tgt_s  = pend_a_r;
                    pend_v_nxt_s = 1'b0;
                end else begin
                    pc_seq_s = pc_r + STEP;
                end
            end
            default: begin
                state_nxt_s  = ST_RAMP;
                pc_seq_s     = RESET_VEC;
                pend_v_nxt_s = 1'b0;
                pend_a_nxt_s = {ADDR_W{1'b0}};
            end
        endcase
    end

`ifdef PCGEN_MISALIGN_CHK_EN
    logic misalign_r;
    logic misalign_nxt_s;

    // Redirect targets are forced onto an instruction boundary and flagged.
    always_comb begin
        pc_nxt_s       = pc_seq_s;
        misalign_nxt_s = misalign_r;
        if (redir_s) begin
            pc_nxt_s       = align_addr(redir_tgt_s);
            misalign_nxt_s = is_misaligned(redir_tgt_s);
        end else begin
            misalign_nxt_s = misalign_r;
        end
    end

    // Misalign flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_nxt_s;
        end
    end

    assign addr_misalign = misalign_r;
`else
    // Redirect targets load verbatim.
    always_comb begin
        pc_nxt_s = pc_seq_s;
        if (redir_s) begin
            pc_nxt_s = redir_tgt_s;
        end else begin
            pc_nxt_s = pc_seq_s;
        end
    end
`endif

    // PC, enable and pending-buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r     <= RESET_VEC;
            ce_r     <= 1'b0;
            pend_v_r <= 1'b0;
            pend_a_r <= {ADDR_W{1'b0}};
        end else begin
            pc_r     <= pc_nxt_s;
            ce_r     <= (state_nxt_s == ST_RUN);
            pend_v_r <= pend_v_nxt_s;
            pend_a_r <= pend_a_nxt_s;
        end
    end

    assign pc               = pc_r;
    assign ce               = ce_r;
    assign redirect_pending = pend_v_r;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pc_gen;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned STALL_W    = 6;
    localparam logic [31:0] RV         = 32'h0000_0000;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [STALL_W-1:0] stall = '0;
    logic               branch = 1'b0;
    logic [ADDR_W-1:0]  b_addr = '0;
    logic               flush = 1'b0;
    logic [ADDR_W-1:0]  flush_addr = '0;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               redirect_pending;
`ifdef PCGEN_MISALIGN_CHK_EN
    logic               addr_misalign;
`endif

    int total = 0;
    int bad   = 0;

    // model state
    logic [31:0] m_pc  = RV;
    logic        m_ce  = 1'b0;
    logic        m_pv  = 1'b0;
    logic [31:0] m_pa  = 32'h0;
    logic        m_mis = 1'b0;
    logic [31:0] m_tgt;
    logic        m_ld;

    pc_gen #(
        .ADDR_W     (ADDR_W),
        .RESET_VEC  (RV),
        .INST_BYTES (INST_BYTES),
        .STALL_W    (STALL_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .branch           (branch),
        .b_addr           (b_addr),
        .flush            (flush),
        .flush_addr       (flush_addr),
        .pc               (pc),
        .ce               (ce),
        .redirect_pending (redirect_pending)
`ifdef PCGEN_MISALIGN_CHK_EN
        ,
        .addr_misalign    (addr_misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] t);
`ifdef PCGEN_MISALIGN_CHK_EN
        return t - (t % INST_BYTES);
`else
        return t;
`endif
    endfunction

    // Behavioural model: applies the priority rules once per rising edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = RV; m_ce = 1'b0; m_pv = 1'b0; m_pa = 32'h0; m_mis = 1'b0;
        end else if (!m_ce) begin
            m_ce = 1'b1;
            m_pc = RV;
        end else begin
            m_ld  = 1'b0;
            m_tgt = 32'h0;
            if (flush) begin
                m_ld = 1'b1; m_tgt = flush_addr; m_pv = 1'b0;
            end else if (stall[0]) begin
                if (branch) begin
                    m_pv = 1'b1; m_pa = b_addr;
                end
            end else if (branch) begin
                m_ld = 1'b1; m_tgt = b_addr; m_pv = 1'b0;
            end else if (m_pv) begin
                m_ld = 1'b1; m_tgt = m_pa; m_pv = 1'b0;
            end else begin
                m_pc = m_pc + INST_BYTES;
            end
            if (m_ld) begin
                m_pc = m_load(m_tgt);
`ifdef PCGEN_MISALIGN_CHK_EN
                m_mis = (m_tgt % INST_BYTES) != 0;
`endif
            end
        end
    end

    // Compare process: every cycle, shortly after the edge.
    always @(posedge clk) begin
        #1;
        chk("pc", pc, m_pc);
        chk("ce", {31'b0, ce}, {31'b0, m_ce});
        chk("pending", {31'b0, redirect_pending}, {31'b0, m_pv});
`ifdef PCGEN_MISALIGN_CHK_EN
        chk("misalign", {31'b0, addr_misalign}, {31'b0, m_mis});
`endif
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_pc", pc, 32'h0);
            chk("rst_ce", {31'b0, ce}, 32'h0);
            chk("rst_pend", {31'b0, redirect_pending}, 32'h0);
        end
        rst = 1'b1;
        step();
        chk("ramp_ce", {31'b0, ce}, 32'h1);
        chk("ramp_pc0", pc, 32'h0);
        step(); chk("seq_4", pc, 32'h4);
        step(); chk("seq_8", pc, 32'h8);
        step(); chk("seq_c", pc, 32'hC);
        step(); chk("seq_10", pc, 32'h10);

        // stalled branch is buffered and applied on release
        stall = 6'b000001;
        step(); chk("stall1_pc", pc, 32'h10);
        branch = 1'b1; b_addr = 32'h200;
        step(); chk("stall2_pc", pc, 32'h10);
        chk("stall2_pend", {31'b0, redirect_pending}, 32'h1);
        branch = 1'b0;
        step(); chk("stall3_pc", pc, 32'h10);
        stall = 6'b000000;
        step(); chk("rel_pc", pc, 32'h200);
        chk("rel_pend", {31'b0, redirect_pending}, 32'h0);
        step(); chk("rel_next", pc, 32'h204);

        // flush beats stall and pending target
        stall = 6'b000001; branch = 1'b1; b_addr = 32'h300;
        step(); chk("fl_pend", {31'b0, redirect_pending}, 32'h1);
        branch = 1'b0; flush = 1'b1; flush_addr = 32'h80;
        step(); chk("fl_pc", pc, 32'h80);
        chk("fl_pend_clr", {31'b0, redirect_pending}, 32'h0);
        flush = 1'b0; stall = 6'b000000;
        step(); chk("fl_next", pc, 32'h84);

        // live branch beats buffered target
        stall = 6'b000001; branch = 1'b1; b_addr = 32'h300;
        step(); chk("lb_hold", pc, 32'h84);
        stall = 6'b000000; b_addr = 32'h400;
        step(); chk("lb_pc", pc, 32'h400);
        chk("lb_pend", {31'b0, redirect_pending}, 32'h0);
        branch = 1'b0;
        step(); chk("lb_next", pc, 32'h404);

        // latest stalled branch wins; upper stall bits are ignored
        stall = 6'b111111; branch = 1'b1; b_addr = 32'h500;
        step(); b_addr = 32'h600;
        step(); branch = 1'b0; stall = 6'b111110;
        step(); chk("latest", pc, 32'h600);
        stall = 6'b000000;

        // wrap
        branch = 1'b1; b_addr = 32'hFFFF_FFF8;
        step(); chk("wr_a", pc, 32'hFFFF_FFF8);
        branch = 1'b0;
        step(); chk("wr_b", pc, 32'hFFFF_FFFC);
        step(); chk("wr_c", pc, 32'h0000_0000);

        // misaligned branch target
        branch = 1'b1; b_addr = 32'h1002;
        step();
`ifdef PCGEN_MISALIGN_CHK_EN
        chk("mis_pc", pc, 32'h1000);
        chk("mis_flag", {31'b0, addr_misalign}, 32'h1);
`else
        chk("mis_pc", pc, 32'h1002);
`endif
        b_addr = 32'h2000;
        step(); chk("al_pc", pc, 32'h2000);
`ifdef PCGEN_MISALIGN_CHK_EN
        chk("al_flag", {31'b0, addr_misalign}, 32'h0);
`endif
        branch = 1'b0;

        // randomized traffic, including occasional mid-run resets
        for (int i = 0; i < 600; i++) begin
            stall      = {5'($urandom), ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0};
            branch     = ($urandom_range(0, 99) < 25);
            b_addr     = rand_addr();
            flush      = ($urandom_range(0, 99) < 6);
            flush_addr = rand_addr();
            rst        = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            step();
        end
        rst = 1'b1; stall = '0; branch = 1'b0; flush = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator and successor to the current single-width PC stage.
- Sits at the head of the pipeline. Drives the instruction-memory address and enable.
- Accepts stall, branch redirect and a new flush redirect from the exception path.
- Adds a one-entry pending-redirect buffer, so a branch resolved during a fetch stall is applied when the stall releases instead of being dropped.

Parameters:
- ADDR_W, 32: width of pc, b_addr and flush_addr.
- RESET_VEC, 32'h00000000: pc value held in reset and while ce=0. Truncated to ADDR_W.
- INST_BYTES, 4: sequential increment. Must be 1, 2, 4 or 8.
- STALL_W, 6: width of the stall vector. Only bit 0 is used here.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-low reset. rst=0 resets the block.
- stall, input, STALL_W: pipeline stall vector. stall[0]=1 freezes pc.
- branch, input, 1: branch redirect request, valid this cycle.
- b_addr, input, ADDR_W: branch target.
- flush, input, 1: exception/flush redirect, highest priority.
- flush_addr, input, ADDR_W: flush target.
- pc, output, ADDR_W: current fetch address (registered).
- ce, output, 1: instruction-memory enable (registered).
- redirect_pending, output, 1: a buffered branch target is waiting.
- addr_misalign, output, 1: last redirect target was misaligned. Present only with PCGEN_MISALIGN_CHK_EN.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_VEC, ce=0, pending buffer empty, redirect_pending=0, addr_misalign=0.
- First rising edge after rst deasserts sets ce=1. Any edge with ce=0 loads pc=RESET_VEC.
  - First valid fetch is RESET_VEC with ce=1.
  - While ce=0, branch, flush and stall are ignored.
- Priority on each edge with ce=1, highest first:
  1. flush=1: pc<=flush_addr. Pending buffer cleared. Applies even when stall[0]=1.
  2. stall[0]=1: pc holds. If branch=1, the buffer captures b_addr and redirect_pending<=1. A later branch during the same stall overwrites it (latest wins).
  3. branch=1: pc<=b_addr. Pending buffer cleared. The live branch beats an older buffered target.
  4. redirect_pending=1: pc<=buffered target. Buffer cleared.
  5. Otherwise: pc<=pc+INST_BYTES, modulo 2^ADDR_W. 0xFFFFFFFC+4 wraps to 0x00000000 when ADDR_W=32.
- Latency: every redirect takes effect on pc at the next rising edge. There is no combinational path from any input to any output.
- redirect_pending mirrors the buffer valid flag. It rises the edge after a stalled branch and falls on the edge the target is consumed or flushed.
- Reset asserted mid-operation: all state returns to reset values immediately, including a pending target. The ce ramp then repeats.
- stall[STALL_W-1:1] have no effect.

Optional Feature:
- Macro: PCGEN_MISALIGN_CHK_EN.
- Defined:
  - Any redirect target (flush, branch or buffered) whose low log2(INST_BYTES) bits are nonzero is loaded with those bits forced to 0.
  - addr_misalign<=1 on that edge.
  - addr_misalign<=0 on the next edge that loads an aligned redirect target, or on reset. Sequential increments leave it unchanged.
- Not defined: targets are loaded verbatim, and the addr_misalign port does not exist.

Test Plan:
- Reset/ramp: hold rst=0 for 3 cycles, release. Required: pc=0, ce=0 until the first edge, then ce=1. Subsequent pc sequence 0, 4, 8, 0xC.
- Stalled branch: at pc=0x10 hold stall=6'b000001 for 3 cycles, with branch=1, b_addr=0x200 in the 2nd cycle. Required: pc stays 0x10, redirect_pending=1. After the stall releases, pc=0x200 on the next edge, then 0x204, and redirect_pending=0.
- Flush beats stall and pending: hold a pending target of 0x300 under stall, then assert flush=1, flush_addr=0x80 with the stall still high. Required: pc=0x80 next edge, redirect_pending=0. After release, pc goes 0x84, not 0x300.
- Live branch beats buffer: with pending target 0x300 and the stall released, assert branch=1, b_addr=0x400 in the same cycle. Required: pc=0x400, buffer cleared.
- Wrap: with pc=0xFFFFFFF8 and no events, two edges. Required: pc=0xFFFFFFFC, then 0x00000000.
- Misalign (macro on): branch to 0x1002. Required: pc=0x1000 and addr_misalign=1. A following aligned branch to 0x2000 gives pc=0x2000 and addr_misalign=0. With the macro off, the same branch gives pc=0x1002.
